// File: rtl/fc_layer_ctrl.sv
// rtl/fc_layer_ctrl.sv - load/settle/capture/drain sequencer for a fully-parallel FC layer
module fc_layer_ctrl #(
    parameter int WIDTH   = 8,
    parameter int IN      = 400,
    parameter int N_OUT   = 120,
    parameter int Z_WIDTH = 25,
    parameter int SETTLE  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic [IN*WIDTH-1:0]      x_vec,
    input  logic [N_OUT*Z_WIDTH-1:0] z_vec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [Z_WIDTH-1:0]       out_data,
    output logic [$clog2(N_OUT)-1:0] out_idx,
    output logic                     out_last,
    output logic                     frame_done
);
    localparam int WR_W  = $clog2(IN);
    localparam int IDX_W = $clog2(N_OUT);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(IN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SETTLE,
        S_WAIT_CAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WR_W-1:0]    wr_idx;
    logic [CNT_W-1:0]   settle_cnt;
    logic [Z_WIDTH-1:0] bank [N_OUT];
    logic               accept;
    logic               out_hs;
    logic               last_hs;
    logic               capture;

    assign accept   = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;
    assign out_last = out_valid & (out_idx == IDX_LAST);
    assign last_hs  = out_hs & out_last;

    // A waiting frame may capture in the same edge the previous frame's final result leaves.
    assign capture  = (state == S_WAIT_CAP) & (~out_valid | last_hs);

    always_comb begin
        state_next = state;
        case (state)
            S_LOAD:     if (accept && (wr_idx == WR_LAST)) state_next = S_SETTLE;
            S_SETTLE:   if (settle_cnt == CNT_LAST)        state_next = S_WAIT_CAP;
            S_WAIT_CAP: if (capture)                       state_next = S_LOAD;
            default:                                       state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_LOAD;
            in_ready   <= 1'b0;
            wr_idx     <= '0;
            settle_cnt <= '0;
            x_vec      <= '0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == S_LOAD);
            if (accept) begin
                x_vec[int'(wr_idx)*WIDTH +: WIDTH] <= in_data;
                wr_idx <= (wr_idx == WR_LAST) ? '0 : wr_idx + WR_W'(1);
            end
            if (state == S_SETTLE) begin
                settle_cnt <= (settle_cnt == CNT_LAST) ? '0 : settle_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            frame_done <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                bank[j] <= '0;
            end
        end else begin
            frame_done <= last_hs;
            if (capture) begin
                for (int j = 0; j < N_OUT; j++) begin
                    bank[j] <= z_vec[j*Z_WIDTH +: Z_WIDTH];
                end
                out_valid <= 1'b1;
                out_idx   <= '0;
            end else if (out_hs) begin
                if (out_idx == IDX_LAST) begin
                    out_valid <= 1'b0;
                    out_idx   <= '0;
                end else begin
                    out_idx <= out_idx + IDX_W'(1);
                end
            end
        end
    end

    assign out_data = bank[out_idx];

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// tb/tb_fc_layer_ctrl.sv - table-driven and randomized bench for fc_layer_ctrl
module tb_fc_layer_ctrl;
    localparam int WIDTH   = 8;
    localparam int IN      = 400;
    localparam int N_OUT   = 120;
    localparam int Z_WIDTH = 25;
    localparam int SETTLE  = 2;
    localparam int IDX_W   = $clog2(N_OUT);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data = '0;
    logic [IN*WIDTH-1:0]      x_vec;
    logic [N_OUT*Z_WIDTH-1:0] z_vec;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [Z_WIDTH-1:0]       out_data;
    logic [IDX_W-1:0]         out_idx;
    logic                     out_last;
    logic                     frame_done;

    fc_layer_ctrl #(
        .WIDTH(WIDTH), .IN(IN), .N_OUT(N_OUT), .Z_WIDTH(Z_WIDTH), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .x_vec(x_vec), .z_vec(z_vec), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Stub neuron j: (j << 12) plus every activation word whose index is j mod N_OUT.
    function automatic logic [N_OUT*Z_WIDTH-1:0] neuron_stub(input logic [IN*WIDTH-1:0] x);
        logic [N_OUT*Z_WIDTH-1:0] z;
        logic [Z_WIDTH-1:0]       s;
        z = '0;
        for (int j = 0; j < N_OUT; j++) begin
            s = Z_WIDTH'(j) << 12;
            for (int i = j; i < IN; i += N_OUT) s = s + Z_WIDTH'(x[i*WIDTH +: WIDTH]);
            z[j*Z_WIDTH +: Z_WIDTH] = s;
        end
        return z;
    endfunction

    assign z_vec = neuron_stub(x_vec);

    typedef struct {
        logic [Z_WIDTH-1:0] data;
        logic [IDX_W-1:0]   idx;
        logic               last;
    } res_t;

    logic [WIDTH-1:0] words [IN];
    res_t             exp_q [$];

    function automatic int model_z(input int j);
        int s;
        s = j * 4096;
        for (int i = 0; i < IN; i++) if (i % N_OUT == j) s += int'(words[i]);
        return s;
    endfunction

    int rmode = 0;
    initial forever begin
        @(negedge clk);
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = ($urandom_range(99) < 60);
            default: out_ready = 1'b0;
        endcase
    end

    int                 hs_cnt = 0;
    int                 done_cnt = 0;
    bit                 done_exp = 1'b0;
    bit                 prev_stall = 1'b0;
    logic [Z_WIDTH-1:0] h_data;
    logic [IDX_W-1:0]   h_idx;
    logic               h_last;
    res_t               r;

    initial forever begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            done_exp   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("frame_done", frame_done, done_exp);
            if (frame_done) done_cnt++;
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, h_data);
                check("hold_idx", out_idx, h_idx);
                check("hold_last", out_last, h_last);
            end
            done_exp = 1'b0;
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got idx %0d data %0h want no result", out_idx, out_data);
                end else begin
                    r = exp_q.pop_front();
                    check("out_data", out_data, r.data);
                    check("out_idx", out_idx, r.idx);
                    check("out_last", out_last, r.last);
                end
                done_exp = out_last;
            end
            prev_stall = out_valid && !out_ready;
            h_data = out_data;
            h_idx  = out_idx;
            h_last = out_last;
        end
    end

    // Drives one frame; lat is cycles from last accept to out_valid (-1 if drain busy, 0 on timeout).
    task automatic send_frame(input int wmode, input int gap_pct, input int abort_at, output int lat);
        int i;
        int guard;
        logic [IN*WIDTH-1:0] exp_x;
        i = 0;
        guard = 0;
        lat = 0;
        for (int k = 0; k < IN; k++) words[k] = (wmode == 0) ? WIDTH'(k % 128) : WIDTH'($urandom);
        while (i < IN) begin
            @(negedge clk);
            if (abort_at >= 0 && i == abort_at) begin
                in_valid = 1'b0;
                return;
            end
            guard++;
            if (guard > 4 * IN) begin
                total++;
                bad++;
                $display("FAIL load_timeout: got %0d words accepted want %0d", i, IN);
                in_valid = 1'b0;
                return;
            end
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = WIDTH'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = words[i];
            end
            if (in_valid && in_ready) i++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < IN; k++) exp_x[k*WIDTH +: WIDTH] = words[k];
        check("x_vec", (x_vec === exp_x), 1);
        for (int j = 0; j < N_OUT; j++) begin
            exp_q.push_back('{data: Z_WIDTH'(model_z(j)), idx: IDX_W'(j), last: (j == N_OUT - 1)});
        end
        if (out_valid) begin
            lat = -1;
        end else begin
            for (int c = 1; c <= 20 && lat == 0; c++) begin
                @(posedge clk);
                #1;
                if (out_valid) begin
                    lat = c;
                    check("in_ready_after_cap", in_ready, 1);
                end else begin
                    check("in_ready_settle", in_ready, 0);
                end
            end
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 5000) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (guard >= 5000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d results pending want 0", exp_q.size());
        end
        @(negedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_x_vec_zero"}, (x_vec == '0), 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_idx"}, out_idx, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    typedef struct {
        int wmode;
        int gap;
        int rmode;
        int exp_lat;
        int exp_hs;
        int exp_done;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int gaps;
        int guard;

        vecs[0] = '{wmode: 0, gap: 0,  rmode: 0, exp_lat: 3, exp_hs: 120, exp_done: 1};
        vecs[1] = '{wmode: 0, gap: 0,  rmode: 1, exp_lat: 3, exp_hs: 120, exp_done: 1};
        vecs[2] = '{wmode: 1, gap: 30, rmode: 2, exp_lat: 3, exp_hs: 120, exp_done: 1};
        vecs[3] = '{wmode: 1, gap: 30, rmode: 1, exp_lat: 3, exp_hs: 120, exp_done: 1};

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_in_ready", in_ready, 1);

        for (int v = 0; v < 4; v++) begin
            rmode    = vecs[v].rmode;
            hs_cnt   = 0;
            done_cnt = 0;
            send_frame(vecs[v].wmode, vecs[v].gap, -1, lat);
            check("latency", lat, vecs[v].exp_lat);
            wait_drain();
            check("handshakes", hs_cnt, vecs[v].exp_hs);
            check("frame_done_count", done_cnt, vecs[v].exp_done);
        end

        // Back-to-back frames held off by the drain side.
        rmode    = 3;
        hs_cnt   = 0;
        done_cnt = 0;
        send_frame(1, 0, -1, lat);
        check("stall_a_latency", lat, 3);
        send_frame(1, 10, -1, lat);
        repeat (6) @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_idx", out_idx, 0);
        rmode = 0;
        gaps  = 0;
        guard = 0;
        while (hs_cnt < 2 * N_OUT && guard < 1000) begin
            @(posedge clk);
            #2;
            if (!out_valid && hs_cnt < 2 * N_OUT) gaps++;
            guard++;
        end
        check("stall_valid_gaps", gaps, 0);
        wait_drain();
        check("stall_handshakes", hs_cnt, 2 * N_OUT);
        check("stall_frame_done_count", done_cnt, 2);
        check("stall_in_ready_after", in_ready, 1);

        // Reset in the middle of a load.
        rmode = 0;
        send_frame(1, 0, 200, lat);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_load");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_load_in_ready", in_ready, 1);

        // Reset in the middle of a drain.
        send_frame(1, 0, -1, lat);
        check("rst_drain_latency", lat, 3);
        guard = 0;
        while (out_idx != IDX_W'(50) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("rst_drain_reach_idx", out_idx, 50);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_drain");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_drain_in_ready", in_ready, 1);

        hs_cnt   = 0;
        done_cnt = 0;
        send_frame(0, 20, -1, lat);
        check("post_reset_latency", lat, 3);
        wait_drain();
        check("post_reset_handshakes", hs_cnt, N_OUT);
        check("post_reset_frame_done_count", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc_layer_ctrl.md
# fc_layer_ctrl

Sequencer for one fully-parallel fully-connected layer built from constant-weight neuron modules, each taking an IN-word activation vector and producing a ReLU'd Z_WIDTH result. It streams IN activations in one word per handshake into a vector register that drives every neuron's `x` input. After a fixed settle time it captures all N_OUT neuron outputs into a bank. It then streams the results out one per handshake, and it loads the next frame while the current one drains.

## Interface
- Clocking: one clock `clk`; reset `rst_n` is synchronous, active-low.
- `WIDTH`, 8: activation word width.
- `IN`, 400: activations per frame (neuron fan-in).
- `N_OUT`, 120: neurons in the layer.
- `Z_WIDTH`, 25: neuron output width (WIDTH*2+$clog2(IN)).
- `SETTLE`, 2: cycles allowed for the combinational neuron array after the vector completes; ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `in_valid` in 1: activation word valid.
- `in_ready` out 1: controller accepts a word.
- `in_data` in WIDTH: activation word; words arrive in index order 0..IN-1.
- `x_vec` out IN*WIDTH: registered activation vector to the neurons; word i occupies bits [i*WIDTH +: WIDTH].
- `z_vec` in N_OUT*Z_WIDTH: neuron outputs; neuron j occupies bits [j*Z_WIDTH +: Z_WIDTH].
- `out_valid` out 1: result word valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out Z_WIDTH: captured result of neuron `out_idx`.
- `out_idx` out $clog2(N_OUT): index of the current result.
- `out_last` out 1: the current result is neuron N_OUT-1.
- `frame_done` out 1: one-cycle pulse after the last result handshake.

## Operation
- Load FSM states:
  - LOAD: `in_ready`=1. Each `in_valid&in_ready` writes `in_data` to x_vec word `wr_idx` and increments `wr_idx`. Acceptance at `wr_idx`==IN-1 goes to SETTLE and clears `wr_idx`.
  - SETTLE: `in_ready`=0. A counter runs SETTLE cycles, then the FSM moves to WAIT_CAP.
  - WAIT_CAP: `in_ready`=0. The capture fires when the drain side is empty, or when the drain side's final handshake (`out_last&out_valid&out_ready`) occurs in the same cycle. The FSM then returns to LOAD.
- Capture edge:
  - Registers all of `z_vec` into the result bank.
  - Sets `out_valid`=1 and `out_idx`=0.
- Drain:
  - `out_data` = bank[`out_idx`].
  - On each handshake, `out_idx` increments.
  - On the handshake at `out_idx`==N_OUT-1: `out_valid` falls, `out_idx` returns to 0, and `frame_done` pulses for one cycle.
  - If a capture coincides with that handshake, `out_valid` stays 1, `out_idx`=0, and the bank reloads with the new frame.
- Result data is stored verbatim. No truncation or sign extension; the ReLU lives in the neurons.
- x_vec is rewritten only in LOAD. Once captured, the bank is independent of x_vec, so loading the next frame never corrupts the drain.
- Mid-operation reset discards the partial frame and the result bank contents. All state returns to its reset values.

## Timing
- Reset values:
  - `in_ready`=0 while `rst_n`=0. It goes to 1 on the first edge with `rst_n`=1 (LOAD entered).
  - `x_vec`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `frame_done`=0.
  - `wr_idx`=0, settle counter=0, bank=0.
- `in_ready` and `out_valid` are registered. Neither depends combinationally on `in_valid` or `out_ready`.
- Latency with an idle drain side: last input accepted on edge t → `out_valid`=1 after edge t+SETTLE+1. With the defaults, the first result is visible 3 cycles after the last input.
- `in_ready` is low from after edge t until the capture edge. It is high again in the cycle after the capture.
- Output holds: `out_data`, `out_idx` and `out_last` are stable while `out_valid&!out_ready`.
- Throughput: one input word per cycle and one result per cycle, sustained.
- Back-pressure: with continuous input, `out_ready`=1 and IN ≥ N_OUT, frame period = IN+SETTLE+1 cycles.

## Test plan
- Reset then 400 words (word i = i mod 128), `out_ready`=1, stub neuron j = sum-of-word-j → after the last accept, `out_valid` rises 3 cycles later. Results stream idx 0..119 with `out_last` only at 119, and `frame_done` pulses once.
- Same stimulus, `out_ready` toggled 1/0 every cycle → each result is held stable while stalled. No index is skipped or duplicated, and exactly 120 handshakes occur.
- Two back-to-back frames with `out_ready`=0 until the second frame's settle ends → second frame stalls in WAIT_CAP with `in_ready`=0. Raising `out_ready` drains frame 1 unchanged, then frame 2 captures on the same edge as frame 1's last handshake, with `out_valid` continuously high.
- `in_valid` gaps (random 30% idle) during LOAD → x_vec word i equals the i-th accepted word. `wr_idx` wraps to 0 only after word 399.
- `rst_n` low for 1 cycle at word 200 of a load and again mid-drain at idx 50 → all outputs reach their reset values. A fresh 400-word frame then produces the correct results from idx 0.
